comm_pkt_xcvr: RTL and testbench

- Parametrised half-duplex packet transceiver for the two-wire differential link (positive line/negative line).
- Serialises an N-byte payload plus a CRC-8 trailer byte, and receives and validates the same framing from the link.
- Adds configurable payload width, bit period, an inter-byte timeout, and explicit CRC/frame error reporting.
- Two instances connect tx_p/tx_n to the peer's rx_p/rx_n for board-to-board or loopback use.

---
 rtl/comm_pkt_xcvr.sv | 238 +++++++++++++++++++++++
 tb/tb_comm_pkt_xcvr.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_pkt_xcvr.sv
// Half-duplex packet transceiver: NBYTES payload + CRC-8 trailer over a differential UART-style link.
// TX serialises MSB byte first, LSB bit first; RX validates framing/CRC and applies an inter-byte timeout.
module comm_pkt_xcvr #(
   parameter int unsigned NBYTES       = 2,
   parameter int unsigned BAUD_DIV     = 16,
   parameter int unsigned TIMEOUT_BITS = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  trmt,
   input  logic [8*NBYTES-1:0]   txdata,
   output logic                  tx_busy,
   output logic                  tx_done,
   output logic                  tx_pkt_done,
   output logic                  tx_p,
   output logic                  tx_n,
   input  logic                  rx_p,
   input  logic                  rx_n,
   output logic [8*NBYTES-1:0]   rxdata,
   output logic                  pckt_rdy,
   input  logic                  clr_pckt_rdy,
   output logic                  crc_err
);
   localparam int unsigned W       = 8 * NBYTES;
   localparam int unsigned BCW     = $clog2(BAUD_DIV);
   localparam int unsigned IW      = $clog2(NBYTES + 1);
   localparam int unsigned TO_CLKS = TIMEOUT_BITS * BAUD_DIV;
   localparam int unsigned TW      = $clog2(TO_CLKS + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_GAP} rx_state_t;

   // CRC-8, poly 0x07, MSB-first, one byte per call
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   tx_state_t        tx_state, tx_state_nxt;
   logic [BCW-1:0]   tx_cnt, tx_cnt_nxt;
   logic [2:0]       tx_bit, tx_bit_nxt;
   logic [IW-1:0]    tx_idx, tx_idx_nxt;
   logic [W-1:0]     tx_sh, tx_sh_nxt;
   logic [7:0]       tx_byte, tx_byte_nxt, tx_crc, tx_crc_nxt;
   logic             tx_busy_nxt, tx_done_nxt, tx_pkt_done_nxt, tx_p_nxt, tx_bit_end;

   rx_state_t        rx_state, rx_state_nxt;
   logic             rx_p_m, rx_p_s, rx_p_d, rx_n_m, rx_n_s, rx_fall;
   logic [BCW-1:0]   rx_cnt, rx_cnt_nxt;
   logic [TW-1:0]    rx_to, rx_to_nxt;
   logic [2:0]       rx_bit, rx_bit_nxt;
   logic [7:0]       rx_byte, rx_byte_nxt, rx_crc, rx_crc_nxt, crc_now;
   logic [IW-1:0]    rx_idx, rx_idx_nxt;
   logic [W-1:0]     rx_sh, rx_sh_nxt, rxdata_nxt;
   logic             rx_ferr, rx_ferr_nxt, ferr_now, pckt_rdy_nxt, crc_err_nxt;
   logic             rx_half, rx_full;

   // TX next-state: byte index NBYTES denotes the CRC trailer
   always_comb begin
      tx_state_nxt    = tx_state;
      tx_cnt_nxt      = tx_cnt;
      tx_bit_nxt      = tx_bit;
      tx_idx_nxt      = tx_idx;
      tx_sh_nxt       = tx_sh;
      tx_byte_nxt     = tx_byte;
      tx_crc_nxt      = tx_crc;
      tx_busy_nxt     = tx_busy;
      tx_done_nxt     = 1'b0;
      tx_pkt_done_nxt = 1'b0;
      tx_p_nxt        = tx_p;
      tx_bit_end      = (tx_cnt == BCW'(BAUD_DIV - 1));
      if (tx_state != TX_IDLE) tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + BCW'(1);
      case (tx_state)
         TX_IDLE: if (trmt) begin
            tx_state_nxt = TX_START;
            tx_busy_nxt  = 1'b1;
            tx_p_nxt     = 1'b0;
            tx_cnt_nxt   = '0;
            tx_idx_nxt   = '0;
            tx_byte_nxt  = txdata[W-1 -: 8];
            tx_sh_nxt    = txdata << 8;
            tx_crc_nxt   = crc8_upd(8'h00, txdata[W-1 -: 8]);
         end
         TX_START: if (tx_bit_end) begin
            tx_state_nxt = TX_DATA;
            tx_bit_nxt   = '0;
            tx_p_nxt     = tx_byte[0];
         end
         TX_DATA: if (tx_bit_end) begin
            if (tx_bit == 3'd7) begin
               tx_state_nxt = TX_STOP;
               tx_p_nxt     = 1'b1;
            end else begin
               tx_bit_nxt  = tx_bit + 3'd1;
               tx_byte_nxt = tx_byte >> 1;
               tx_p_nxt    = tx_byte[1];
            end
         end
         TX_STOP: if (tx_bit_end) begin
            tx_done_nxt = 1'b1;
            if (tx_idx == IW'(NBYTES)) begin
               tx_state_nxt    = TX_IDLE;
               tx_busy_nxt     = 1'b0;
               tx_pkt_done_nxt = 1'b1;
            end else begin
               tx_state_nxt = TX_START;
               tx_p_nxt     = 1'b0;
               tx_idx_nxt   = tx_idx + IW'(1);
               if (tx_idx == IW'(NBYTES - 1)) begin
                  tx_byte_nxt = tx_crc;
               end else begin
                  tx_byte_nxt = tx_sh[W-1 -: 8];
                  tx_sh_nxt   = tx_sh << 8;
                  tx_crc_nxt  = crc8_upd(tx_crc, tx_sh[W-1 -: 8]);
               end
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // RX next-state: mid-bit sampling, running CRC, inter-byte timeout in GAP
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_to_nxt    = rx_to;
      rx_bit_nxt   = rx_bit;
      rx_byte_nxt  = rx_byte;
      rx_crc_nxt   = rx_crc;
      rx_idx_nxt   = rx_idx;
      rx_sh_nxt    = rx_sh;
      rx_ferr_nxt  = rx_ferr;
      rxdata_nxt   = rxdata;
      pckt_rdy_nxt = clr_pckt_rdy ? 1'b0 : pckt_rdy;
      crc_err_nxt  = crc_err;
      rx_fall      = rx_p_d & ~rx_p_s;
      rx_half      = (rx_cnt == BCW'(BAUD_DIV / 2 - 1));
      rx_full      = (rx_cnt == BCW'(BAUD_DIV - 1));
      ferr_now     = rx_ferr | ~rx_p_s;
      crc_now      = crc8_upd(rx_crc, rx_byte);
      if (rx_state == RX_START || rx_state == RX_DATA || rx_state == RX_STOP)
         rx_cnt_nxt = rx_cnt + BCW'(1);
      case (rx_state)
         RX_IDLE: if (rx_fall) begin
            rx_state_nxt = RX_START;
            rx_cnt_nxt   = '0;
         end
         RX_START: if (rx_half) begin
            rx_cnt_nxt = '0;
            if (rx_p_s) begin
               // glitch: mid-packet it falls back to GAP so the timeout still applies
               rx_state_nxt = (rx_idx == '0) ? RX_IDLE : RX_GAP;
            end else begin
               rx_state_nxt = RX_DATA;
               rx_bit_nxt   = '0;
               if (rx_idx == '0) begin
                  pckt_rdy_nxt = 1'b0;
                  crc_err_nxt  = 1'b0;
                  rx_ferr_nxt  = 1'b0;
                  rx_crc_nxt   = 8'h00;
               end
            end
         end
         RX_DATA: if (rx_full) begin
            rx_cnt_nxt  = '0;
            rx_byte_nxt = {rx_p_s, rx_byte[7:1]};
            if (rx_p_s == rx_n_s) rx_ferr_nxt = 1'b1;
            if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            else rx_bit_nxt = rx_bit + 3'd1;
         end
         RX_STOP: if (rx_full) begin
            rx_cnt_nxt  = '0;
            rx_ferr_nxt = ferr_now;
            rx_crc_nxt  = crc_now;
            if (rx_idx == IW'(NBYTES)) begin
               rx_state_nxt = RX_IDLE;
               rx_idx_nxt   = '0;
               if (crc_now == 8'h00 && !ferr_now) begin
                  rxdata_nxt   = rx_sh;
                  pckt_rdy_nxt = 1'b1;
                  crc_err_nxt  = 1'b0;
               end else begin
                  pckt_rdy_nxt = 1'b0;
                  crc_err_nxt  = 1'b1;
               end
            end else begin
               rx_sh_nxt    = (rx_sh << 8) | W'(rx_byte);
               rx_idx_nxt   = rx_idx + IW'(1);
               rx_to_nxt    = '0;
               rx_state_nxt = RX_GAP;
            end
         end
         RX_GAP: begin
            if (rx_fall) begin
               rx_state_nxt = RX_START;
               rx_cnt_nxt   = '0;
            end else if (rx_to == TW'(TO_CLKS - 1)) begin
               rx_state_nxt = RX_IDLE;
               rx_idx_nxt   = '0;
               pckt_rdy_nxt = 1'b0;
               crc_err_nxt  = 1'b1;
            end else begin
               rx_to_nxt = rx_to + TW'(1);
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;   tx_cnt <= '0;   tx_bit <= '0;   tx_idx <= '0;
         tx_sh <= '0;           tx_byte <= '0;  tx_crc <= '0;
         tx_busy <= 1'b0;       tx_done <= 1'b0; tx_pkt_done <= 1'b0;
         tx_p <= 1'b1;          tx_n <= 1'b0;
         rx_p_m <= 1'b1;        rx_p_s <= 1'b1; rx_p_d <= 1'b1;
         rx_n_m <= 1'b0;        rx_n_s <= 1'b0;
         rx_state <= RX_IDLE;   rx_cnt <= '0;   rx_to <= '0;    rx_bit <= '0;
         rx_byte <= '0;         rx_crc <= '0;   rx_idx <= '0;   rx_sh <= '0;
         rx_ferr <= 1'b0;       rxdata <= '0;   pckt_rdy <= 1'b0; crc_err <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt; tx_cnt <= tx_cnt_nxt; tx_bit <= tx_bit_nxt;
         tx_idx <= tx_idx_nxt;     tx_sh <= tx_sh_nxt;   tx_byte <= tx_byte_nxt;
         tx_crc <= tx_crc_nxt;     tx_busy <= tx_busy_nxt;
         tx_done <= tx_done_nxt;   tx_pkt_done <= tx_pkt_done_nxt;
         tx_p <= tx_p_nxt;         tx_n <= ~tx_p_nxt;
         rx_p_m <= rx_p;           rx_p_s <= rx_p_m;     rx_p_d <= rx_p_s;
         rx_n_m <= rx_n;           rx_n_s <= rx_n_m;
         rx_state <= rx_state_nxt; rx_cnt <= rx_cnt_nxt; rx_to <= rx_to_nxt;
         rx_bit <= rx_bit_nxt;     rx_byte <= rx_byte_nxt; rx_crc <= rx_crc_nxt;
         rx_idx <= rx_idx_nxt;     rx_sh <= rx_sh_nxt;   rx_ferr <= rx_ferr_nxt;
         rxdata <= rxdata_nxt;     pckt_rdy <= pckt_rdy_nxt; crc_err <= crc_err_nxt;
      end
   end
endmodule

// File: tb/tb_comm_pkt_xcvr.sv
// Two-instance bench: A transmits to B; line decoded independently, CRC modelled by polynomial division.
module tb_comm_pkt_xcvr;
   localparam int unsigned NB  = 2;
   localparam int unsigned BD  = 4;
   localparam int unsigned TOB = 12;
   localparam int unsigned W   = 8 * NB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_trmt = 1'b0;
   logic [W-1:0] a_txdata = '0;
   logic         a_busy, a_done, a_pkt_done, a_tx_p, a_tx_n, a_rdy, a_err;
   logic [W-1:0] a_rxdata;
   logic         b_busy, b_done, b_pkt_done, b_tx_p, b_tx_n, b_rdy, b_err;
   logic [W-1:0] b_rxdata;
   logic         b_clr = 1'b0;
   logic         force_low = 1'b0, inj_en = 1'b0, inj_p = 1'b1;
   logic         b_rx_p, b_rx_n;

   assign b_rx_p = inj_en ? inj_p : (force_low ? 1'b0 : a_tx_p);
   assign b_rx_n = inj_en ? ~inj_p : a_tx_n;

   comm_pkt_xcvr #(.NBYTES(NB), .BAUD_DIV(BD), .TIMEOUT_BITS(TOB)) u_a (
      .clk(clk), .rst_n(rst_n), .trmt(a_trmt), .txdata(a_txdata),
      .tx_busy(a_busy), .tx_done(a_done), .tx_pkt_done(a_pkt_done),
      .tx_p(a_tx_p), .tx_n(a_tx_n), .rx_p(b_tx_p), .rx_n(b_tx_n),
      .rxdata(a_rxdata), .pckt_rdy(a_rdy), .clr_pckt_rdy(1'b0), .crc_err(a_err));

   comm_pkt_xcvr #(.NBYTES(NB), .BAUD_DIV(BD), .TIMEOUT_BITS(TOB)) u_b (
      .clk(clk), .rst_n(rst_n), .trmt(1'b0), .txdata('0),
      .tx_busy(b_busy), .tx_done(b_done), .tx_pkt_done(b_pkt_done),
      .tx_p(b_tx_p), .tx_n(b_tx_n), .rx_p(b_rx_p), .rx_n(b_rx_n),
      .rxdata(b_rxdata), .pckt_rdy(b_rdy), .clr_pckt_rdy(b_clr), .crc_err(b_err));

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0, pkt_cnt = 0, busy_cyc = 0;
   logic [7:0] mon_q [0:255];
   int mon_cnt = 0;

   always @(negedge clk) begin
      if (a_done) done_cnt++;
      if (a_pkt_done) pkt_cnt++;
      if (a_busy) busy_cyc++;
   end

   // independent line decoder for A's tx_p
   initial begin : line_mon
      logic prev;
      logic [7:0] b;
      prev = 1'b1;
      b = '0;
      forever begin
         @(negedge clk);
         if (prev && !a_tx_p && rst_n) begin
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = a_tx_p;
            end
            repeat (BD) @(negedge clk);
            mon_q[8'(mon_cnt)] = b;
            mon_cnt++;
         end
         prev = a_tx_p;
      end
   end

   // CRC as remainder of message*x^8 modulo x^8+x^2+x+1
   function automatic logic [7:0] model_crc(input logic [W-1:0] d);
      logic [W+7:0] m;
      m = {d, 8'h00};
      for (int i = W + 7; i >= 8; i--)
         if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
      return m[7:0];
   endfunction

   task automatic send_a(input logic [W-1:0] d);
      @(negedge clk);
      a_txdata = d;
      a_trmt   = 1'b1;
      @(negedge clk);
      a_trmt   = 1'b0;
   endtask

   task automatic wait_pkt(input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (pkt_cnt != base) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_tx_p, a_tx_n, a_busy, a_done, a_pkt_done, b_rdy, b_err} !== 7'b1000000)
         $display("FAIL reset_flags: got %b want 1000000",
                  {a_tx_p, a_tx_n, a_busy, a_done, a_pkt_done, b_rdy, b_err});
      else n_pass++;
      n_checks++;
      if (b_rxdata !== '0) $display("FAIL reset_rxdata: got %h want 0000", b_rxdata);
      else n_pass++;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      int db, pb, bb, mb;
      bit ok;
      db = done_cnt; pb = pkt_cnt; bb = busy_cyc; mb = mon_cnt;
      send_a(16'h1234);
      wait_pkt(pb, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_timeout: got no tx_pkt_done want one"); else n_pass++;
      n_checks++;
      if (done_cnt - db != 3) $display("FAIL basic_done_cnt: got %0d want 3", done_cnt - db);
      else n_pass++;
      n_checks++;
      if (busy_cyc - bb != 3 * 10 * BD) $display("FAIL basic_busy_span: got %0d want %0d", busy_cyc - bb, 3 * 10 * BD);
      else n_pass++;
      n_checks++;
      if (mon_cnt - mb != 3 || mon_q[8'(mb)] !== 8'h12 || mon_q[8'(mb + 1)] !== 8'h34 || mon_q[8'(mb + 2)] !== 8'hF1)
         $display("FAIL basic_line: got %0d bytes %h %h %h want 3 bytes 12 34 f1", mon_cnt - mb,
                  mon_q[8'(mb)], mon_q[8'(mb + 1)], mon_q[8'(mb + 2)]);
      else n_pass++;
      n_checks++;
      if ({b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, 16'h1234})
         $display("FAIL basic_rx: got rdy=%b err=%b data=%h want 1 0 1234", b_rdy, b_err, b_rxdata);
      else n_pass++;
   endtask

   task automatic test_flag_clear();
      int pb;
      bit ok;
      pb = pkt_cnt;
      send_a(16'h9669);
      repeat (10) @(negedge clk);
      n_checks++;
      if (b_rdy !== 1'b0) $display("FAIL rdy_clear_at_start: got %b want 0", b_rdy); else n_pass++;
      wait_pkt(pb, ok);
      n_checks++;
      if (!ok || {b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, 16'h9669})
         $display("FAIL second_pkt_rx: got ok=%b rdy=%b err=%b data=%h want 1 1 0 9669", ok, b_rdy, b_err, b_rxdata);
      else n_pass++;
   endtask

   task automatic test_crc_corrupt();
      int k, pb;
      bit ok;
      pb = pkt_cnt;
      k = 0;
      send_a(16'h9669);
      for (int i = 0; i < 300 && k < 2; i++) begin
         @(negedge clk);
         if (a_done) k++;
      end
      n_checks++;
      if (k != 2) $display("FAIL corrupt_wait: got %0d tx_done want 2", k); else n_pass++;
      repeat (4) @(negedge clk);
      force_low = 1'b1;
      repeat (2 * BD) @(negedge clk);
      force_low = 1'b0;
      wait_pkt(pb, ok);
      n_checks++;
      if ({b_rdy, b_err, b_rxdata} !== {1'b0, 1'b1, 16'h9669})
         $display("FAIL corrupt_rx: got rdy=%b err=%b data=%h want 0 1 9669", b_rdy, b_err, b_rxdata);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d1;
      int db, pb, mb;
      bit ok;
      d1 = W'($urandom);
      db = done_cnt; pb = pkt_cnt; mb = mon_cnt;
      @(negedge clk); a_txdata = d1; a_trmt = 1'b1;
      @(negedge clk); a_trmt = 1'b0;
      @(negedge clk); a_txdata = ~d1; a_trmt = 1'b1;
      @(negedge clk); a_trmt = 1'b0;
      wait_pkt(pb, ok);
      repeat (60) @(negedge clk);
      n_checks++;
      if (!ok || done_cnt - db != 3 || pkt_cnt - pb != 1)
         $display("FAIL ignore_trmt_counts: got done=%0d pkt=%0d want 3 1", done_cnt - db, pkt_cnt - pb);
      else n_pass++;
      n_checks++;
      if (mon_cnt - mb != 3 || {mon_q[8'(mb)], mon_q[8'(mb + 1)], mon_q[8'(mb + 2)]} !== {d1, model_crc(d1)})
         $display("FAIL ignore_trmt_line: got %h%h%h want %h%h", mon_q[8'(mb)], mon_q[8'(mb + 1)],
                  mon_q[8'(mb + 2)], d1, model_crc(d1));
      else n_pass++;
      n_checks++;
      if ({b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, d1})
         $display("FAIL ignore_trmt_rx: got rdy=%b err=%b data=%h want 1 0 %h", b_rdy, b_err, b_rxdata, d1);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [W-1:0] prev_rx;
      logic [7:0] inj;
      int pb;
      bit ok;
      prev_rx = b_rxdata;
      inj = 8'h5A;
      @(negedge clk);
      inj_en = 1'b1; inj_p = 1'b1;
      repeat (BD) @(negedge clk);
      inj_p = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         inj_p = inj[i];
         repeat (BD) @(negedge clk);
      end
      inj_p = 1'b1;
      repeat (BD) @(negedge clk);
      repeat (30) @(negedge clk);
      n_checks++;
      if ({b_rdy, b_err} !== 2'b00) $display("FAIL timeout_early: got rdy=%b err=%b want 0 0", b_rdy, b_err);
      else n_pass++;
      repeat (30) @(negedge clk);
      n_checks++;
      if ({b_rdy, b_err, b_rxdata} !== {1'b0, 1'b1, prev_rx})
         $display("FAIL timeout_abort: got rdy=%b err=%b data=%h want 0 1 %h", b_rdy, b_err, b_rxdata, prev_rx);
      else n_pass++;
      inj_en = 1'b0;
      pb = pkt_cnt;
      send_a(16'hABCD);
      wait_pkt(pb, ok);
      n_checks++;
      if (!ok || {b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, 16'hABCD})
         $display("FAIL after_timeout_rx: got ok=%b rdy=%b err=%b data=%h want 1 1 0 abcd", ok, b_rdy, b_err, b_rxdata);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      int pb, mb;
      bit ok;
      for (int n = 0; n < 5; n++) begin
         d = W'($urandom);
         pb = pkt_cnt; mb = mon_cnt;
         send_a(d);
         wait_pkt(pb, ok);
         n_checks++;
         if (!ok || {b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, d})
            $display("FAIL random_rx_%0d: got ok=%b rdy=%b err=%b data=%h want 1 1 0 %h", n, ok, b_rdy, b_err, b_rxdata, d);
         else n_pass++;
         n_checks++;
         if (mon_cnt - mb != 3 || {mon_q[8'(mb)], mon_q[8'(mb + 1)], mon_q[8'(mb + 2)]} !== {d, model_crc(d)})
            $display("FAIL random_line_%0d: got %h%h%h want %h%h", n, mon_q[8'(mb)], mon_q[8'(mb + 1)],
                     mon_q[8'(mb + 2)], d, model_crc(d));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int db, pb, mb;
      bit ok;
      send_a(16'h5A5A);
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_tx_p, a_tx_n, a_busy, b_rdy} !== 4'b1000)
         $display("FAIL async_reset: got tx_p=%b tx_n=%b busy=%b rdy=%b want 1 0 0 0", a_tx_p, a_tx_n, a_busy, b_rdy);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      db = done_cnt; pb = pkt_cnt; mb = mon_cnt;
      send_a(16'h00FF);
      wait_pkt(pb, ok);
      n_checks++;
      if (!ok || done_cnt - db != 3 || {b_rdy, b_err, b_rxdata} !== {1'b1, 1'b0, 16'h00FF})
         $display("FAIL post_reset_rx: got done=%0d rdy=%b err=%b data=%h want 3 1 0 00ff", done_cnt - db, b_rdy, b_err, b_rxdata);
      else n_pass++;
      n_checks++;
      if (mon_cnt - mb != 3 || {mon_q[8'(mb)], mon_q[8'(mb + 1)], mon_q[8'(mb + 2)]} !== {16'h00FF, model_crc(16'h00FF)})
         $display("FAIL post_reset_line: got %h%h%h want 00ff%h", mon_q[8'(mb)], mon_q[8'(mb + 1)],
                  mon_q[8'(mb + 2)], model_crc(16'h00FF));
      else n_pass++;
   endtask

   task automatic test_clr();
      logic [W-1:0] d;
      int hi;
      @(negedge clk);
      b_clr = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({b_rdy, b_err, b_rxdata} !== {1'b0, 1'b0, 16'h00FF})
         $display("FAIL clr_pckt_rdy: got rdy=%b err=%b data=%h want 0 0 00ff", b_rdy, b_err, b_rxdata);
      else n_pass++;
      // clear held high: the completion set must still show for exactly one cycle
      d = W'($urandom);
      hi = 0;
      send_a(d);
      repeat (160) begin
         @(negedge clk);
         if (b_rdy) hi++;
      end
      b_clr = 1'b0;
      n_checks++;
      if (hi != 1 || b_rxdata !== d)
         $display("FAIL set_beats_clr: got %0d high cycles data=%h want 1 %h", hi, b_rxdata, d);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flag_clear();
      test_crc_corrupt();
      test_back_to_back();
      test_timeout();
      test_random();
      test_reset_mid();
      test_clr();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
